// File: rtl/rom_reader_pkg.sv
// Shared constants and FSM state encoding for the rom_reader frame streamer.
package rom_reader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] FRAME_HDR = 8'h5A;
  localparam logic [7:0] FRAME_TRL = 8'h6B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rom_reader_skid.sv
// Two-entry in-order output FIFO carrying a data word plus its last flag.
module rom_reader_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              head_vld,
  output logic [1:0]        occ
);

  logic [1:0][DATA_W-1:0] ent_data;
  logic [1:0]             ent_last;
  logic [1:0]             cnt;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_data <= '0;
      ent_last <= '0;
      cnt      <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          ent_data[cnt[0]] <= push_data;
          ent_last[cnt[0]] <= push_last;
          cnt              <= cnt + 2'd1;
        end
        2'b01: begin
          ent_data[0] <= ent_data[1];
          ent_last[0] <= ent_last[1];
          cnt         <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent_data[0] <= push_data;
            ent_last[0] <= push_last;
          end else begin
            ent_data[0] <= ent_data[1];
            ent_last[0] <= ent_last[1];
            ent_data[1] <= push_data;
            ent_last[1] <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = ent_data[0];
  assign head_last = ent_last[0];
  assign head_vld  = (cnt != 2'd0);
  assign occ       = cnt;

endmodule

// File: rtl/rom_reader.sv
// Streams one 2**ADDR_W-word frame from a registered-output ROM into a
// valid/ready sink. Optional header/trailer check: ROM_READER_FRAME_CHECK_EN.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
`ifdef ROM_READER_FRAME_CHECK_EN
  output logic              frame_err,
`endif
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state;
  logic              pend_a;   // rom_addr holds a fresh address the ROM samples next edge
  logic              rd_vld;   // rom_data holds a word not yet pushed
  logic [ADDR_W-1:0] rd_addr;
  logic              push, pop, rdv_n, issue, drained, buf_last, rd_last;
  logic [1:0]        occ;
  logic [2:0]        occ_n, credit;
  logic [ADDR_W-1:0] addr_inc;

  assign pop      = out_valid & out_ready;
  assign push     = rd_vld & ((occ != 2'd2) | pop);
  assign occ_n    = {1'b0, occ} + {2'b0, push} - {2'b0, pop};
  assign rdv_n    = pend_a | (rd_vld & ~push);
  assign rd_last  = (rd_addr == LAST_ADDR);
  assign addr_inc = rom_addr + ADDR_W'(1);
  assign drained  = (occ_n == 3'd0) & ~rdv_n;

  // While the address is held, the ROM keeps returning the same word, so the
  // ROM output register acts as a third slot when the sink is flowing. With
  // the sink stalled only the two buffer entries are reserved.
  assign credit = occ_n + {2'b0, rdv_n} + {2'b0, ~out_ready};
  assign issue  = (state == S_RUN) & (credit < 3'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      pend_a   <= 1'b0;
      rd_vld   <= 1'b0;
      rd_addr  <= '0;
    end else begin
      pend_a <= issue | ((state == S_IDLE) & start);
      rd_vld <= rdv_n;
      if (pend_a) rd_addr <= rom_addr;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_RUN;
          rom_addr <= '0;
        end
        S_RUN: if (issue) begin
          rom_addr <= addr_inc;
          if (addr_inc == LAST_ADDR) state <= S_DRAIN;
        end
        S_DRAIN: if (drained) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  rom_reader_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rom_data),
    .push_last (rd_last),
    .pop       (pop),
    .head_data (out_data),
    .head_last (buf_last),
    .head_vld  (out_valid),
    .occ       (occ)
  );

  assign out_last = out_valid & buf_last;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

`ifdef ROM_READER_FRAME_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if ((state == S_IDLE) & start) begin
      frame_err <= 1'b0;
    end else if (push & (((rd_addr == '0) & (rom_data != DATA_W'(FRAME_HDR))) |
                         (rd_last & (rom_data != DATA_W'(FRAME_TRL))))) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader: stimulus queues expected words, a monitor
// pops and compares on every transfer and checks stall stability.
module tb_rom_reader;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk, rst, start, out_ready;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, out_data;
  logic       out_valid, out_last, busy, done;
`ifdef ROM_READER_FRAME_CHECK_EN
  logic       frame_err;
`endif

  logic [7:0] img [16];
  exp_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         xfer_cnt = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  rom_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
`ifdef ROM_READER_FRAME_CHECK_EN
    .frame_err (frame_err),
`endif
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-output ROM model
  always @(posedge clk) rom_data <= img[rom_addr];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic load_frame();
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.data = img[i];
      e.last = (i == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(input string nm, input bit rnd, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
      if (done) seen = 1'b1;
    end
    chk(nm, seen, 1'b1);
  endtask

  // Monitor: runs just after the falling edge, sees what the next rising edge samples
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_last", out_last, e.last);
        end
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, n;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    img[0] = 8'h5A;
    for (int i = 1; i < 15; i++) img[i] = 8'h7E;
    img[15] = 8'h6B;
    repeat (2) @(negedge clk);

    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", rom_addr, 4'h0);
`ifdef ROM_READER_FRAME_CHECK_EN
    chk("rst_frame_err", frame_err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Basic frame with exact latency
    load_frame();
    pulse_start();                       // after edge N
    chk("t1_busy", busy, 1'b1);
    chk("t1_addr0", rom_addr, 4'h0);
    @(negedge clk);                      // N+1
    chk("t1_n1_valid", out_valid, 1'b0);
    @(negedge clk);                      // N+2
    chk("t1_n2_valid", out_valid, 1'b1);
    chk("t1_n2_data", out_data, 8'h5A);
    repeat (15) @(negedge clk);          // N+17
    chk("t1_n17_last", out_last, 1'b1);
    chk("t1_n17_data", out_data, 8'h6B);
    @(negedge clk);                      // N+18
    chk("t1_n18_done", done, 1'b1);
    chk("t1_n18_valid", out_valid, 1'b0);
    @(negedge clk);                      // N+19
    chk("t1_n19_done", done, 1'b0);
    chk("t1_n19_busy", busy, 1'b0);
    chk("t1_addr_hold", rom_addr, 4'hF);

    // Random backpressure
    load_frame();
    pulse_start();
    run_until_done("t2_done", 1'b1, 400);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_idle", busy, 1'b0);
    chk("t2_q_empty", exp_q.size(), 0);

    // Sink stalled from start
    out_ready = 1'b0;
    load_frame();
    pulse_start();
    repeat (9) @(negedge clk);
    chk("t3_addr_stop", rom_addr, 4'h1);
    chk("t3_valid", out_valid, 1'b1);
    chk("t3_head", out_data, 8'h5A);
    out_ready = 1'b1;
    run_until_done("t3_done", 1'b0, 100);
    chk("t3_q_empty", exp_q.size(), 0);
    @(negedge clk);

    // start held high: back-to-back frames with one IDLE cycle between
    load_frame();
    load_frame();
    start = 1'b1;
    run_until_done("t4_done1", 1'b0, 100);
    @(negedge clk);
    chk("t4_idle_gap", busy, 1'b0);
    @(negedge clk);
    chk("t4_restart_busy", busy, 1'b1);
    chk("t4_restart_addr", rom_addr, 4'h0);
    run_until_done("t4_done2", 1'b0, 100);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_idle_end", busy, 1'b0);
    chk("t4_q_empty", exp_q.size(), 0);

    // Reset mid-frame after word 7
    load_frame();
    target = xfer_cnt + 8;
    pulse_start();
    n = 0;
    while (xfer_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_w7", xfer_cnt >= target, 1'b1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_data", out_data, 8'h00);
    chk("t5_rst_last", out_last, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_addr", rom_addr, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_stay_idle", busy, 1'b0);
    load_frame();
    pulse_start();
    run_until_done("t5_done", 1'b0, 100);
    chk("t5_q_empty", exp_q.size(), 0);
    @(negedge clk);

`ifdef ROM_READER_FRAME_CHECK_EN
    // Bad header then good frame
    img[0] = 8'h5B;
    load_frame();
    pulse_start();
    @(negedge clk);
    chk("t6_err_pre", frame_err, 1'b0);
    @(negedge clk);
    chk("t6_err_set", frame_err, 1'b1);
    run_until_done("t6_done1", 1'b0, 100);
    chk("t6_err_hold", frame_err, 1'b1);
    @(negedge clk);
    img[0] = 8'h5A;
    load_frame();
    pulse_start();
    chk("t6_err_clear", frame_err, 1'b0);
    run_until_done("t6_done2", 1'b0, 100);
    chk("t6_err_good", frame_err, 1'b0);
    @(negedge clk);
`endif

    chk("final_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
